// File: rtl/relax_osc_counter_if.sv
// Bus between a relaxation-oscillator frequency counter and its controller.
// The master drives the comparator and the measurement requests; the slave returns the result and the capacitor control.
interface relax_osc_counter_if #(
    parameter int CNT_W = 8,
    parameter int NCAP  = 2,
    parameter int WIN_W = 10
);
    logic             cmp;
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic             ack;
    logic [NCAP-1:0]  sel_cap;
    logic             rst_out;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             busy;
    logic             ovf;

    modport master (
        output cmp, start, win_len, ack,
        input  sel_cap, rst_out, count, valid, busy, ovf
    );

    modport slave (
        input  cmp, start, win_len, ack,
        output sel_cap, rst_out, count, valid, busy, ovf
    );
endinterface

// File: rtl/relax_osc_counter.sv
// Relaxation-oscillator period counter: counts comparator edges over a clk window and ping-pongs the capacitors.
// Define RELAX_OSC_CNT_SAT_EN to make the count saturate; otherwise it wraps. In both builds ovf is sticky.
module relax_osc_counter #(
    parameter int CNT_W = 8,
    parameter int NCAP  = 2,
    parameter int WIN_W = 10
) (
    input logic              clk,
    input logic              rst,
    relax_osc_counter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [NCAP-1:0]  sel_q, sel_d;
    logic             rot_q, rot_d;
    logic             rst_out_q, rst_out_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             cmp_edge;
    logic             load;

    // sync_q[1:0] is the two-flop synchronizer; sync_q[2] is the edge-detect delay.
    assign cmp_edge = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[1:0], bus.cmp};
        sel_d     = sel_q;
        rot_d     = cmp_edge;
        rst_out_d = rot_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        win_d     = win_q;
        load      = 1'b0;

        if (cmp_edge) begin
            sel_d = {sel_q[NCAP-2:0], sel_q[NCAP-1]};
        end

        case (state_q)
            IDLE: begin
                load = bus.start;
            end
            MEASURE: begin
                win_d = win_q - WIN_W'(1);
                if (cmp_edge) begin
`ifdef RELAX_OSC_CNT_SAT_EN
                    if (count_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
`else
                    count_d = count_q + CNT_W'(1);
                    if (count_q == '1) begin
                        ovf_d = 1'b1;
                    end
`endif
                end
                if (win_q == WIN_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.ack) begin
                    state_d = IDLE;
                    load    = bus.start;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A zero-length window skips MEASURE and presents an empty result.
        if (load) begin
            win_d   = bus.win_len;
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = (bus.win_len != '0) ? MEASURE : DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            sel_q     <= NCAP'(1);
            rot_q     <= 1'b0;
            rst_out_q <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            win_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            sel_q     <= sel_d;
            rot_q     <= rot_d;
            rst_out_q <= rst_out_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            win_q     <= win_d;
        end
    end

    assign bus.sel_cap = sel_q;
    assign bus.rst_out = rst_out_q;
    assign bus.count   = count_q;
    assign bus.ovf     = ovf_q;
    assign bus.valid   = (state_q == DONE);
    assign bus.busy    = (state_q == MEASURE);
endmodule

// File: doc/relax_osc_counter.md
RELAX_OSC_COUNTER -- requirements
Module: relax_osc_counter

Interface
REQ-001 Parameter CNT_W, default 8, result counter width.
REQ-002 Parameter NCAP, default 2, number of ping-pong capacitors (>=2).
REQ-003 Parameter WIN_W, default 10, measurement window length width.
REQ-004 clk  input  1  reference clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cmp  input  1  asynchronous comparator output; rising edge = one oscillator period.
REQ-007 start  input  1  begin measurement; sampled only in IDLE.
REQ-008 win_len  input  WIN_W  window length in clk cycles, sampled with start.
REQ-009 ack  input  1  consumer acknowledges result.
REQ-010 sel_cap  output  NCAP  one-hot capacitor select.
REQ-011 rst_out  output  1  one-cycle discharge pulse for deselected capacitor.
REQ-012 count  output  CNT_W  measured edge count, stable while valid=1.
REQ-013 valid  output  1  result available.
REQ-014 busy  output  1  high in MEASURE.
REQ-015 ovf  output  1  counter overflowed during the window.

Function
REQ-016 cmp SHALL pass a 2-flop synchronizer; edge = sync_out & ~sync_out_d (third flop).
REQ-017 cmp high first sampled at edge k -> edge asserted at k+2 -> sel_cap/count update at k+2; cmp high and low each >=2 clk periods.
REQ-018 Each detected edge, in every state, SHALL rotate sel_cap one bit left (MSB wraps to bit 0).
REQ-019 rst_out SHALL pulse high exactly the cycle after each rotation, never otherwise.
REQ-020 FSM states IDLE, MEASURE, DONE; reset state IDLE.
REQ-021 IDLE & start & win_len!=0 -> MEASURE: window counter <= win_len, count <= 0, ovf <= 0, valid <= 0.
REQ-022 IDLE & start & win_len==0 -> DONE directly, count=0, ovf=0.
REQ-023 MEASURE: window counter decrements each clk; each edge increments count.
REQ-024 Window counter ==1 -> DONE next edge, so MEASURE lasts exactly win_len cycles; edge in last MEASURE cycle SHALL be counted.
REQ-025 DONE: valid=1, count/ovf frozen; edges ignored by count.
REQ-026 DONE & ack -> IDLE, valid=0; DONE & ack & start -> MEASURE directly (REQ-021 rules).
REQ-027 start in MEASURE or DONE without ack SHALL be ignored; ack outside DONE ignored.
REQ-028 busy = (state==MEASURE).

Reset
REQ-029 rst SHALL immediately force: state IDLE, sel_cap=1 (bit 0), rst_out=0, count=0, valid=0, busy=0, ovf=0, synchronizer flops 0, window counter 0.
REQ-030 rst mid-MEASURE or mid-DONE SHALL discard the result; no valid after release until new start.
REQ-031 First clk edge after rst deassertion SHALL accept start normally.

Configuration
REQ-032 Macro RELAX_OSC_CNT_SAT_EN.
REQ-033 Defined: count saturates at 2^CNT_W-1; edge at saturation sets ovf, count holds.
REQ-034 Undefined: count wraps modulo 2^CNT_W; edge at 2^CNT_W-1 yields 0 and sets ovf.
REQ-035 ovf sticky until next start or rst in both builds.

Verification
REQ-036 rst, start win_len=100, cmp period 10 clk -> valid after 100 cycles, count=10, ovf=0, sel_cap cycled 01,10,01...; ack -> valid=0 next cycle.
REQ-037 CNT_W=4, win_len=200, cmp period 8 clk (25 edges) -> SAT_EN: count=15, ovf=1; without: count=9, ovf=1.
REQ-038 win_len=0 start -> valid next cycle, count=0; cmp edges meanwhile still rotate sel_cap and pulse rst_out.
REQ-039 cmp edge timed to update in final MEASURE cycle -> counted; edge one cycle later -> not counted, sel_cap still rotates.
REQ-040 rst at cycle 50 of 100-cycle window -> all outputs at reset values same cycle; no valid until new start.
REQ-041 NCAP=3: 4 edges -> sel_cap 001,010,100,001,010; one rst_out pulse per edge; start during MEASURE ignored.
